// File: rtl/i2c_slave_link_controller.sv
// I2C slave link controller: synchronises SCL/SDA, detects START/STOP, shifts address and
// data bytes, schedules ACK/NACK and serialises read data toward an open-drain SDA pad.
module i2c_slave_link_controller #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic       busy,
    output logic       rw,
    output logic       stop_seen
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_RX,
        ST_RX_ACK,
        ST_TX,
        ST_TX_ACK,
        ST_WAIT_STOP
    } state_e;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;

    state_e     state_q, state_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic       byte_done_q, byte_done_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_q, tx_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_load_q, tx_load_d;
    logic       busy_q, busy_d;
    logic       rw_q, rw_d;
    logic       stop_seen_q, stop_seen_d;

    logic scl_s, sda_s;
    logic scl_rise, scl_fall, start_det, stop_det;
    logic load_tx;

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  =  scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s &  scl_prev_q;
    // SCL must be high on both samples so an SDA edge racing an SCL edge is not a START/STOP.
    assign start_det = scl_s & scl_prev_q &  sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q &  sda_s;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        byte_done_d = byte_done_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        sda_oe_d    = sda_oe_q;
        rx_data_d   = rx_data_q;
        busy_d      = busy_q;
        rw_d        = rw_q;
        rx_valid_d  = 1'b0;
        tx_load_d   = 1'b0;
        stop_seen_d = 1'b0;
        load_tx     = 1'b0;

        if (stop_det) begin
            state_d     = ST_IDLE;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
            stop_seen_d = 1'b1;
            bitcnt_d    = 3'd0;
            byte_done_d = 1'b0;
        end else if (start_det) begin
            state_d     = ST_ADDR;
            sda_oe_d    = 1'b0;
            bitcnt_d    = 3'd0;
            byte_done_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_ADDR, ST_RX: begin
                    if (scl_rise) begin
                        shift_d  = {shift_q[6:0], sda_s};
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) byte_done_d = 1'b1;
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        if (state_q == ST_ADDR) begin
                            if (shift_q[7:1] == SLAVE_ADDR) begin
                                sda_oe_d = 1'b1;
                                rw_d     = shift_q[0];
                                busy_d   = 1'b1;
                                state_d  = ST_ADDR_ACK;
                            end else begin
                                sda_oe_d = 1'b0;
                                busy_d   = 1'b0;
                                state_d  = ST_WAIT_STOP;
                            end
                        end else if (rx_ready) begin
                            sda_oe_d   = 1'b1;
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            state_d    = ST_RX_ACK;
                        end else begin
                            sda_oe_d = 1'b0;
                            busy_d   = 1'b0;
                            state_d  = ST_WAIT_STOP;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw_q) begin
                            load_tx = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            bitcnt_d = 3'd0;
                            state_d  = ST_RX;
                        end
                    end
                end
                ST_RX_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        bitcnt_d = 3'd0;
                        state_d  = ST_RX;
                    end
                end
                ST_TX: begin
                    if (scl_rise) begin
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) byte_done_d = 1'b1;
                    end else if (scl_fall) begin
                        if (byte_done_q) begin
                            byte_done_d = 1'b0;
                            sda_oe_d    = 1'b0;
                            state_d     = ST_TX_ACK;
                        end else begin
                            sda_oe_d = ~tx_q[7];
                            tx_d     = {tx_q[6:0], 1'b0};
                        end
                    end
                end
                ST_TX_ACK: begin
                    // byte_done_q doubles as "master ACK sampled" while waiting for the slot's fall.
                    if (scl_rise) begin
                        if (sda_s) begin
                            busy_d  = 1'b0;
                            state_d = ST_WAIT_STOP;
                        end else begin
                            byte_done_d = 1'b1;
                        end
                    end else if (scl_fall && byte_done_q) begin
                        load_tx = 1'b1;
                    end
                end
                ST_WAIT_STOP: begin
                    sda_oe_d = 1'b0;
                    busy_d   = 1'b0;
                end
                default: state_d = ST_IDLE;
            endcase

            if (load_tx) begin
                tx_d        = {tx_data[6:0], 1'b0};
                tx_load_d   = 1'b1;
                sda_oe_d    = ~tx_data[7];
                bitcnt_d    = 3'd0;
                byte_done_d = 1'b0;
                state_d     = ST_TX;
            end
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (RST) begin
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            state_q     <= ST_IDLE;
            bitcnt_q    <= 3'd0;
            byte_done_q <= 1'b0;
            shift_q     <= 8'd0;
            tx_q        <= 8'd0;
            sda_oe_q    <= 1'b0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            tx_load_q   <= 1'b0;
            busy_q      <= 1'b0;
            rw_q        <= 1'b0;
            stop_seen_q <= 1'b0;
        end else begin
            scl_sync_q  <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q  <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_prev_q  <= scl_s;
            sda_prev_q  <= sda_s;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            byte_done_q <= byte_done_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            sda_oe_q    <= sda_oe_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_load_q   <= tx_load_d;
            busy_q      <= busy_d;
            rw_q        <= rw_d;
            stop_seen_q <= stop_seen_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign tx_load   = tx_load_q;
    assign busy      = busy_q;
    assign rw        = rw_q;
    assign stop_seen = stop_seen_q;

endmodule
